scan_chain_ctrl: RTL
====================

// Module: scan_chain_ctrl
// PURPOSE
//  Sequences one scan test on a chain of CHAIN_LEN negedge-clocked muxed-scan flops
//  (SE/SI/SO style cells with a SETB input), one pattern per START.
//  Per START: shift in a pattern, run CAP_CYCLES functional captures, shift out the response.
//  Sits between the test host (register or JTAG front end) and the chain's SE/SI/SO/clock-enable pins.
// PARAMETERS
//  CHAIN_LEN  8  number of flops in the chain; must be >= 2
//  CAPW       4  width of the CAP_CYCLES field
// PORTS
//  CLK         in   1          controller clock; chain flops clock on the falling edge of the gated CLK
//  RST         in   1          synchronous, active-high reset
//  START       in   1          begin a test; accepted only in IDLE
//  ABORT       in   1          stop the current test and return to IDLE
//  PAT_IN      in   CHAIN_LEN  pattern to load; bit i ends up in chain position i (0 = nearest SI)
//  CAP_CYCLES  in   CAPW       number of capture cycles; 0 = flush test, no capture
//  SO          in   1          serial output of the last flop in the chain
//  SE          out  1          scan enable to every chain flop
//  SI          out  1          serial input to chain position 0
//  CHAIN_CE    out  1          clock enable for the chain's clock gate
//  CHAIN_SETB  out  1          active-low preset to the chain
//  BUSY        out  1          high while not in IDLE
//  DONE        out  1          1-cycle pulse; RESP_OUT is valid from this cycle on
//  RESP_OUT    out  CHAIN_LEN  captured response; bit i comes from chain position i
// BEHAVIOUR
//  Clocking and reset
//  - Every output is registered and updates on the rising edge of CLK.
//  - The chain samples SE and SI on the falling edge inside the same cycle (half-cycle setup).
//  - RST, or the first cycle after RST: state=IDLE, SE=0, SI=0, CHAIN_CE=0, BUSY=0, DONE=0, RESP_OUT=0.
//  - CHAIN_SETB is driven low for exactly the first cycle after RST is released (presets the chain), then held 1.
//  - RST asserted mid-test: outputs go to the reset values on the next edge, no DONE is produced,
//    and the SETB preset pulse is issued again after release.
//  State machine: IDLE -> SHIFT_IN -> CAPTURE -> SHIFT_OUT -> DONE -> IDLE
//  - IDLE: on START, latch PAT_IN into the shift register and CAP_CYCLES into the counter.
//    START is ignored in every other state.
//  - SHIFT_IN (CHAIN_LEN cycles): SE=1, CHAIN_CE=1.
//    In cycle k (k=0..N-1), SI = PAT[N-1-k], so the MSB is sent first.
//  - CAPTURE (CAP_CYCLES cycles): SE=0, CHAIN_CE=1, SI=0.
//    If CAP_CYCLES=0, the state is skipped and SHIFT_IN goes directly to SHIFT_OUT.
//  - SHIFT_OUT (CHAIN_LEN cycles): SE=1, CHAIN_CE=1, SI=0.
//    SO is sampled on the rising edge that starts each SHIFT_OUT cycle k.
//    Each sample is written to RESP_OUT[N-1-k].
//  - DONE (1 cycle): DONE=1, SE=0, CHAIN_CE=0, then return to IDLE.
//    RESP_OUT holds its value until the next DONE or RST.
//  - Latency: with START accepted at edge 0 and N=CHAIN_LEN, C=CAP_CYCLES,
//    DONE is high during cycle 2N+C+1.
//  - ABORT in any non-IDLE state: next cycle is IDLE with SE=0, CHAIN_CE=0, no DONE;
//    RESP_OUT is left unchanged.
//  - ABORT and START together in IDLE: ABORT wins and START is dropped.
//  - Counters are sized clog2(CHAIN_LEN) and CAPW bits and never wrap within a phase.
//    The maximum capture count is 2^CAPW-1.
// TESTING
//  - Flush: N=8, PAT_IN=8'hA5, CAP_CYCLES=0, chain modelled as 8 scan flops
//    -> SI sequence 1,0,1,0,0,1,0,1; RESP_OUT=8'hA5; DONE in cycle 17.
//  - Capture: chain functional D = ~Q, PAT_IN=8'hA5, CAP_CYCLES=1
//    -> SE low for exactly 1 cycle; RESP_OUT=8'h5A; DONE in cycle 18.
//  - Even captures: same model, CAP_CYCLES=2 -> RESP_OUT=8'hA5; CHAIN_CE high for 18 cycles.
//  - START while BUSY (pulsed in cycle 5) -> ignored; DONE pulses exactly once; BUSY drops after DONE.
//  - ABORT in cycle 4 of SHIFT_IN -> SE=0 and BUSY=0 next cycle; no DONE; RESP_OUT unchanged.
//    A fresh START then completes normally.
//  - RST in the middle of SHIFT_OUT -> all outputs at reset values next cycle.
//    CHAIN_SETB is low for exactly 1 cycle after RST release; no DONE.

Source files
------------

// File: rtl/scan_chain_ctrl.sv
// Scan chain test sequencer: shift-in, capture, shift-out
// for one pattern per START on a negedge muxed-scan chain.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 8,
  parameter int CAPW      = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic [CAPW-1:0]      CAP_CYCLES,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 CHAIN_CE,
  output logic                 CHAIN_SETB,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP_OUT
);

  localparam int CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);
  localparam logic [CAPW-1:0] CAP_ONE = CAPW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_CAPTURE,
    S_SHIFT_OUT,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic                   r_se;
  logic                   r_si;
  logic                   r_ce;
  logic                   r_setb;
  logic                   r_busy;
  logic                   r_done;
  logic [CHAIN_LEN-1:0]   r_resp;
  logic [CHAIN_LEN-1:0]   r_sh;
  logic [CW-1:0]          r_cnt;
  logic [CAPW-1:0]        r_cap;
  logic [CHAIN_LEN-1:0]   w_sh_in;

  // Pattern bits leave at the MSB while SO responses enter at the LSB,
  // so one register serves both shift directions.
  assign w_sh_in = {r_sh[CHAIN_LEN-2:0], SO};

  assign SE         = r_se;
  assign SI         = r_si;
  assign CHAIN_CE   = r_ce;
  assign CHAIN_SETB = r_setb;
  assign BUSY       = r_busy;
  assign DONE       = r_done;
  assign RESP_OUT   = r_resp;

  // Test sequencer FSM with registered chain controls
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_se    <= 1'b0;
      r_si    <= 1'b0;
      r_ce    <= 1'b0;
      r_setb  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_resp  <= '0;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_cap   <= '0;
    end else begin
      r_setb <= 1'b1;
      r_done <= 1'b0;
      if (ABORT) begin
        r_state <= S_IDLE;
        r_se    <= 1'b0;
        r_si    <= 1'b0;
        r_ce    <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (START) begin
              r_state <= S_SHIFT_IN;
              r_sh    <= PAT_IN;
              r_cap   <= CAP_CYCLES;
              r_cnt   <= '0;
              r_si    <= PAT_IN[CHAIN_LEN-1];
              r_se    <= 1'b1;
              r_ce    <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
          S_SHIFT_IN: begin
            if (r_cnt == LAST) begin
              r_cnt <= '0;
              r_si  <= 1'b0;
              if (r_cap == '0) begin
                // Flush: first response bit is already on SO
                r_state <= S_SHIFT_OUT;
                r_sh    <= w_sh_in;
              end else begin
                r_state <= S_CAPTURE;
                r_se    <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
              r_si  <= r_sh[CHAIN_LEN-2];
              r_sh  <= {r_sh[CHAIN_LEN-2:0], 1'b0};
            end
          end
          S_CAPTURE: begin
            if (r_cap == CAP_ONE) begin
              r_state <= S_SHIFT_OUT;
              r_se    <= 1'b1;
              r_sh    <= w_sh_in;
            end else begin
              r_cap <= r_cap - 1'b1;
            end
          end
          S_SHIFT_OUT: begin
            if (r_cnt == LAST) begin
              r_state <= S_DONE;
              r_resp  <= r_sh;
              r_done  <= 1'b1;
              r_se    <= 1'b0;
              r_ce    <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
              r_sh  <= w_sh_in;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_se    <= 1'b0;
            r_ce    <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
